// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder controller.
//   DEF_WIDTH / DEF_DEPTH : default payload width and outstanding-tag count
//   tag_w()               : tag width for a given depth
package reorder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // A depth of 1 would give a zero-width tag; keep at least one bit.
  function automatic int tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rob_slot_mem.sv
// Payload storage for the reorder buffer.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_idx  : slot written
//   wr_data : payload written
//   rd_idx  : slot read (combinational)
//   rd_data : payload at rd_idx
// Contents are not reset; validity is tracked by the controller.
module rob_slot_mem
  import reorder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TW    = tag_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [TW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [TW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/reorder_ctrl.sv
// Reorder controller: hands out tags in order, accepts responses in any
// order, and releases payloads strictly in tag-allocation order.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/ready/tag : tag allocation handshake
//   rsp_valid/tag/data  : out-of-order response (always accepted)
//   out_valid/ready     : in-order retire handshake
//   out_data/out_tag    : head payload and its tag
//   err                 : sticky flag for responses to free or completed tags
module reorder_ctrl
  import reorder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [tag_w(DEPTH)-1:0] req_tag,
  input  logic                    rsp_valid,
  input  logic [tag_w(DEPTH)-1:0] rsp_tag,
  input  logic [WIDTH-1:0]        rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [tag_w(DEPTH)-1:0] out_tag,
  output logic                    err
);

  localparam int TW = tag_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0]    alloc_ptr, ret_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] allocd, done;

  logic do_alloc, do_ret, rsp_ok, rsp_bad;

  // Ready comes only from registered occupancy, so a same-cycle retire
  // never opens a slot for allocation until the following cycle.
  assign req_ready = (count != CW'(DEPTH));
  assign req_tag   = alloc_ptr;
  assign do_alloc  = req_valid & req_ready;

  assign out_valid = done[ret_ptr];
  assign out_tag   = ret_ptr;
  assign do_ret    = out_valid & out_ready;

  // The slot being allocated this cycle is still free in registered state,
  // so a response naming it already fails the allocated check; the explicit
  // term keeps that intent visible.
  assign rsp_ok  = rsp_valid & allocd[rsp_tag] & ~done[rsp_tag] &
                   ~(do_alloc & (rsp_tag == alloc_ptr));
  assign rsp_bad = rsp_valid & ~rsp_ok;

  // Alloc slot, retire slot and accepted-response slot are always distinct:
  // alloc_ptr == ret_ptr only when empty (no retire) or full (no alloc),
  // and a response to the done head is rejected.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      ret_ptr   <= '0;
      count     <= '0;
      allocd    <= '0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      if (do_alloc) begin
        allocd[alloc_ptr] <= 1'b1;
        done[alloc_ptr]   <= 1'b0;
        alloc_ptr         <= alloc_ptr + 1'b1;
      end
      if (rsp_ok) done[rsp_tag] <= 1'b1;
      if (do_ret) begin
        allocd[ret_ptr] <= 1'b0;
        done[ret_ptr]   <= 1'b0;
        ret_ptr         <= ret_ptr + 1'b1;
      end
      case ({do_alloc, do_ret})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rsp_bad) err <= 1'b1;
    end
  end

  rob_slot_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (rsp_ok),
    .wr_idx  (rsp_tag),
    .wr_data (rsp_data),
    .rd_idx  (ret_ptr),
    .rd_data (out_data)
  );

endmodule

// File: doc/reorder_ctrl.md
REORDER_CTRL -- requirements
Module: reorder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the response payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of outstanding tags; legal range 2..16, power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  requester asks for a tag.
REQ-006 SHALL have port req_ready  output  1  a tag is free; allocation occurs when req_valid & req_ready.
REQ-007 SHALL have port req_tag  output  $clog2(DEPTH)  the tag granted on allocation.
REQ-008 SHALL have port rsp_valid  input  1  an out-of-order response arrives; always accepted.
REQ-009 SHALL have port rsp_tag  input  $clog2(DEPTH)  the tag of the response.
REQ-010 SHALL have port rsp_data  input  WIDTH  the response payload.
REQ-011 SHALL have port out_valid  output  1  the in-order head response is available.
REQ-012 SHALL have port out_ready  input  1  the consumer accepts; retire occurs when out_valid & out_ready.
REQ-013 SHALL have port out_data  output  WIDTH  the head payload.
REQ-014 SHALL have port out_tag  output  $clog2(DEPTH)  the head tag.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL keep an allocation pointer, a retire pointer (both wrap DEPTH-1 -> 0), an occupancy count of $clog2(DEPTH+1) bits, and per-slot allocated and done bits.
REQ-017 SHALL drive req_ready = (count != DEPTH), derived from registered state only; a retire in the same cycle does not free a slot for allocation until the next cycle.
REQ-018 SHALL drive req_tag = allocation pointer, valid whether or not req_valid is high.
REQ-019 On allocation SHALL set allocated[tag], clear done[tag], and advance the allocation pointer.
REQ-020 On rsp_valid with allocated[rsp_tag]=1 and done[rsp_tag]=0 SHALL write rsp_data into slot storage and set done[rsp_tag].
REQ-021 On rsp_valid to an unallocated or already-done tag SHALL ignore the data, leave slot state unchanged, and set err.
REQ-022 SHALL drive out_valid = done[retire pointer], out_tag = retire pointer, and out_data = storage[retire pointer]; a response to the head tag appears on out_valid exactly one cycle after rsp_valid.
REQ-023 On retire SHALL clear allocated and done for the head slot and advance the retire pointer.
REQ-024 SHALL update count by +1 on allocation only, -1 on retire only, and leave it unchanged when both occur in the same cycle.
REQ-025 SHALL accept a response in the same cycle as a retire or allocation of a different tag with no loss.
REQ-026 SHALL treat a response naming the tag being allocated in that same cycle as an error per REQ-021.
REQ-027 SHALL hold out_valid, out_data and out_tag stable while out_valid=1 and out_ready=0.

Reset
REQ-028 While rst=1 on a clock edge SHALL clear both pointers, count, all allocated, done and err bits; after reset req_ready=1, req_tag=0, out_valid=0, out_tag=0, err=0.
REQ-029 A reset asserted mid-operation SHALL discard all outstanding tags; slot payload storage is not reset, and out_data is don't-care while out_valid=0.

Structure
REQ-030 SHALL place the tag type width function and the DEPTH/WIDTH defaults in shared package reorder_pkg.
REQ-031 SHALL instantiate one sub-module, rob_slot_mem: DEPTH x WIDTH storage with one indexed write port and one combinational indexed read port, no reset.

Verification
REQ-032 Reset, then allocate 4 tags back-to-back -> req_tag 0,1,2,3; req_ready=0 after the 4th; count=4.
REQ-033 With tags 0-3 outstanding, respond in order 2,3,1,0 with data A2,A3,A1,A0 -> out_valid stays 0 until tag 0 returns, then A0,A1,A2,A3 retire on 4 consecutive cycles with out_ready=1.
REQ-034 When full, assert out_ready on the head while req_valid=1 -> req_ready stays 0 in that cycle; allocation of tag 0 occurs next cycle and req_tag wraps to 0.
REQ-035 Respond to unallocated tag 1 after reset -> err=1 and remains 1; out_valid=0; count=0.
REQ-036 With head done, hold out_ready=0 for 3 cycles -> out_data and out_tag are stable; assert rst mid-stream -> next cycle req_ready=1, out_valid=0, err=0.
REQ-037 Issue a response, an allocation and a retire in one cycle (three distinct tags) -> count unchanged and the response data retires correctly later.
